uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter OVS, 16, s_tick pulses per bit period (even value, >=8).
REQ-002 SHALL have parameter MAXDBITS, 8, width of the dout port and of the data shift register.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_tick  input  1  oversample enable, one clk wide, OVS per bit.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous, idle high.
REQ-007 SHALL have port cfg_dbits  input  2  data bits: 0=5, 1=6, 2=7, 3=8.
REQ-008 SHALL have port cfg_parity  input  2  parity mode: 0=none, 1=even, 2=odd, 3=none.
REQ-009 SHALL have port cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port dout  output  MAXDBITS  received word, right-justified, unused MSBs 0.
REQ-011 SHALL have port rx_valid  output  1  dout and status flags hold a word not yet consumed.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts the word on clk when rx_valid=1.
REQ-013 SHALL have ports parity_err, frame_err, break_det, overrun  output  1 each  status flags bound to the current word.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all FSM decisions use the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-016 IDLE: rxs=0 SHALL move to START, clear the tick and bit counters, and latch cfg_* into shadow registers; cfg changes mid-frame have no effect.
REQ-017 START: on the s_tick making OVS/2 ticks, rxs=1 SHALL return to IDLE (glitch, no word, no flags); rxs=0 SHALL go to DATA with the tick counter cleared.
REQ-018 DATA: every OVS s_ticks, rxs SHALL be sampled into bit position bit_cnt (LSB first); after shadow-dbits bits, go to PARITY if parity is enabled, else to STOP.
REQ-019 PARITY: after OVS s_ticks, sample rxs; parity_err_next=1 if XOR(data bits, sampled bit) is 1 for even parity or 0 for odd parity.
REQ-020 STOP: sample rxs after OVS s_ticks, and after a further OVS s_ticks if stop2 is set; any sample of 0 SHALL set frame_err_next.
REQ-021 Break: all data bits 0, parity bit 0 (if present) and the first stop sample 0 SHALL set break_det_next; break_det implies frame_err.
REQ-022 On the final stop sample, the next clk SHALL load dout, the flags and rx_valid=1; this is the one-cycle delivery latency.
REQ-023 After the final stop sample, the FSM SHALL go to IDLE if rxs=1, else to BRK_WAIT; BRK_WAIT SHALL go to IDLE only when rxs=1, so no start bit is detected while the line is held low.
REQ-024 Handshake: rx_valid&rx_ready SHALL clear rx_valid next cycle; dout and flags SHALL hold stable while rx_valid=1 and no new word loads.
REQ-025 Load while rx_valid=1 and rx_ready=0: the new word SHALL overwrite dout and the flags, set overrun=1 and keep rx_valid=1.
REQ-026 Load in the same cycle as rx_valid&rx_ready: the new word SHALL load, rx_valid stays 1, overrun=0.
REQ-027 Counters SHALL be sized for OVS-1 and MAXDBITS-1; the tick counter SHALL wrap to 0 at every sample point.

Reset
REQ-028 On rst=1 the FSM SHALL go to IDLE, counters and shadow cfg to 0, dout=0, rx_valid=0, all flags 0, synchronizer flops to 1.
REQ-029 rst mid-frame SHALL discard the partial frame; after release, a start is detected only after rxs has been 1 then 0.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state encodings, the parity-mode constants and the cfg_dbits code-to-count mapping.
REQ-031 The synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value 1); all other logic stays in uart_rx_cfg.

Verification
REQ-032 8N1, OVS=16, byte 0xA5, rx_ready=1 -> dout=0xA5, rx_valid for 1 cycle, all flags 0.
REQ-033 7E2, data 0x41 with correct parity bit 0 -> dout=0x41, parity_err=0; same frame with parity bit 1 -> parity_err=1.
REQ-034 8O1, stop bit driven 0, byte 0x3C -> frame_err=1, break_det=0, rx_valid=1.
REQ-035 rx held low for 3 frame times -> one word dout=0x00, break_det=1, frame_err=1; no further word until rx returns high.
REQ-036 Two 8N1 frames 0x11, 0x22 with rx_ready=0 -> dout=0x22, overrun=1; then rx_ready=1 -> rx_valid=0 next cycle.
REQ-037 rx low pulse of 4 s_ticks -> no word, FSM back in IDLE; rst asserted mid-DATA -> all outputs 0 and a following valid frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity-mode codes and
// the mapping from the 2-bit data-length code to an actual bit count.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE     = 2'd0;
    localparam logic [1:0] PAR_EVEN     = 2'd1;
    localparam logic [1:0] PAR_ODD      = 2'd2;
    localparam logic [1:0] PAR_NONE_ALT = 2'd3;

    // Code 0..3 selects 5..8 data bits.
    function automatic logic [3:0] dbitsCount(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    function automatic logic parityEnabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// the idle-high level so reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with parity/frame/break detection
// and a valid/ready output register that flags overruns.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVS      = 16,
    parameter int MAXDBITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_tick,
    input  logic                rx,
    input  logic [1:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic [MAXDBITS-1:0] dout,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    output logic                overrun
);

    localparam int TW = $clog2(OVS);
    localparam int BW = (MAXDBITS > 1) ? $clog2(MAXDBITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);

    logic w_rxs;

    rx_state_t r_state;
    rx_state_t w_stateNext;

    logic [TW-1:0]       r_tickCnt,  w_tickNext;
    logic [BW-1:0]       r_bitCnt,   w_bitNext;
    logic [MAXDBITS-1:0] r_data,     w_dataNext;
    logic [1:0]          r_shDbits,  w_shDbitsNext;
    logic [1:0]          r_shParity, w_shParityNext;
    logic                r_shStop2,  w_shStop2Next;
    logic                r_parBit,   w_parBitNext;
    logic                r_perrPend, w_perrNext;
    logic                r_ferrPend, w_ferrNext;
    logic                r_brkPend,  w_brkNext;
    logic                r_lineSeen;
    logic                w_load;
    logic                w_lastBit;

    logic [MAXDBITS-1:0] r_dout;
    logic                r_rxValid;
    logic                r_parityErr;
    logic                r_frameErr;
    logic                r_breakDet;
    logic                r_overrun;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rxs)
    );

    assign w_lastBit = (int'(r_bitCnt) == int'(dbitsCount(r_shDbits)) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_tickNext     = r_tickCnt;
        w_bitNext      = r_bitCnt;
        w_dataNext     = r_data;
        w_shDbitsNext  = r_shDbits;
        w_shParityNext = r_shParity;
        w_shStop2Next  = r_shStop2;
        w_parBitNext   = r_parBit;
        w_perrNext     = r_perrPend;
        w_ferrNext     = r_ferrPend;
        w_brkNext      = r_brkPend;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A start only counts once the line has been seen idle since reset.
                if (!w_rxs && r_lineSeen) begin
                    w_stateNext    = ST_START;
                    w_tickNext     = '0;
                    w_bitNext      = '0;
                    w_dataNext     = '0;
                    w_shDbitsNext  = cfg_dbits;
                    w_shParityNext = cfg_parity;
                    w_shStop2Next  = cfg_stop2;
                    w_parBitNext   = 1'b0;
                    w_perrNext     = 1'b0;
                    w_ferrNext     = 1'b0;
                    w_brkNext      = 1'b0;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (r_tickCnt == TICK_MID) begin
                        w_tickNext  = '0;
                        w_stateNext = w_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tickNext = r_tickCnt + TW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (r_tickCnt == TICK_LAST) begin
                        w_tickNext           = '0;
                        w_dataNext[r_bitCnt] = w_rxs;
                        if (w_lastBit) begin
                            w_bitNext   = '0;
                            w_stateNext = parityEnabled(r_shParity) ? ST_PARITY : ST_STOP;
                        end else begin
                            w_bitNext = r_bitCnt + BW'(1);
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TW'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (r_tickCnt == TICK_LAST) begin
                        w_tickNext   = '0;
                        w_parBitNext = w_rxs;
                        w_perrNext   = (^r_data) ^ w_rxs ^ (r_shParity == PAR_ODD);
                        w_stateNext  = ST_STOP;
                    end else begin
                        w_tickNext = r_tickCnt + TW'(1);
                    end
                end
            end

            ST_STOP: begin
                // r_bitCnt doubles as the stop-bit index here (0 = first stop).
                if (s_tick) begin
                    if (r_tickCnt == TICK_LAST) begin
                        w_tickNext = '0;
                        if (!w_rxs) begin
                            w_ferrNext = 1'b1;
                        end
                        if (r_bitCnt == '0) begin
                            w_brkNext = (r_data == '0) && !r_parBit && !w_rxs;
                        end
                        if (!r_shStop2 || (r_bitCnt != '0)) begin
                            w_load      = 1'b1;
                            w_bitNext   = '0;
                            w_stateNext = w_rxs ? ST_IDLE : ST_BRK_WAIT;
                        end else begin
                            w_bitNext = BW'(1);
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TW'(1);
                    end
                end
            end

            ST_BRK_WAIT: begin
                if (w_rxs) begin
                    w_stateNext = ST_IDLE;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tickCnt  <= '0;
            r_bitCnt   <= '0;
            r_data     <= '0;
            r_shDbits  <= '0;
            r_shParity <= '0;
            r_shStop2  <= 1'b0;
            r_parBit   <= 1'b0;
            r_perrPend <= 1'b0;
            r_ferrPend <= 1'b0;
            r_brkPend  <= 1'b0;
            r_lineSeen <= 1'b0;
        end else begin
            r_tickCnt  <= w_tickNext;
            r_bitCnt   <= w_bitNext;
            r_data     <= w_dataNext;
            r_shDbits  <= w_shDbitsNext;
            r_shParity <= w_shParityNext;
            r_shStop2  <= w_shStop2Next;
            r_parBit   <= w_parBitNext;
            r_perrPend <= w_perrNext;
            r_ferrPend <= w_ferrNext;
            r_brkPend  <= w_brkNext;
            if (w_rxs) begin
                r_lineSeen <= 1'b1;
            end
        end
    end

    // A new word always wins; overrun records that the previous one was unread.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= '0;
            r_rxValid   <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
            r_breakDet  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_load) begin
            r_dout      <= r_data;
            r_rxValid   <= 1'b1;
            r_parityErr <= w_perrNext;
            r_frameErr  <= w_ferrNext;
            r_breakDet  <= w_brkNext;
            r_overrun   <= r_rxValid && !rx_ready;
        end else if (r_rxValid && rx_ready) begin
            r_rxValid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign rx_valid   = r_rxValid;
    assign parity_err = r_parityErr;
    assign frame_err  = r_frameErr;
    assign break_det  = r_breakDet;
    assign overrun    = r_overrun;

endmodule
